// File: rtl/div_sequencer_if.sv
// div_sequencer_if
//   Control bundle between the division sequencer, the instruction decoder
//   (Start/Done handshake) and the bitslice array (strobes and status).
//   master : the sequencer; samples request/status, drives strobes.
//   slave  : decoder/array side; drives request/status, samples strobes.
interface div_sequencer_if;
  // request and array status
  logic Start;
  logic Op1Sign;
  logic Op2Sign;
  logic Op2Zero;
  logic Trial_Neg;
  // handshake back to the decoder
  logic Busy;
  logic Done;
  logic DivZero;
  // bitslice strobes
  logic LOAD_DIVH;
  logic LOAD_DIVL;
  logic INV_OP1;
  logic OP1_INV_Cin;
  logic INV_OP2;
  logic OP2_INV_Cin;
  logic DIVH_P;
  logic DIVL_P;
  logic LOAD_ACC;
  logic RESULT_P;
  logic INV_RESULT;
  logic RESULT_INV_Cin;
  logic INV_REM;
  logic STORE_QUOT;
  logic STORE_REM;

  modport master (
    input  Start, Op1Sign, Op2Sign, Op2Zero, Trial_Neg,
    output Busy, Done, DivZero,
    output LOAD_DIVH, LOAD_DIVL, INV_OP1, OP1_INV_Cin, INV_OP2, OP2_INV_Cin,
    output DIVH_P, DIVL_P, LOAD_ACC, RESULT_P,
    output INV_RESULT, RESULT_INV_Cin, INV_REM, STORE_QUOT, STORE_REM
  );

  modport slave (
    output Start, Op1Sign, Op2Sign, Op2Zero, Trial_Neg,
    input  Busy, Done, DivZero,
    input  LOAD_DIVH, LOAD_DIVL, INV_OP1, OP1_INV_Cin, INV_OP2, OP2_INV_Cin,
    input  DIVH_P, DIVL_P, LOAD_ACC, RESULT_P,
    input  INV_RESULT, RESULT_INV_Cin, INV_REM, STORE_QUOT, STORE_REM
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
//   Control FSM stepping a WIDTH-slice array through one signed restoring
//   division: LOAD (operand magnitudes), WIDTH x ITER (shift/trial subtract),
//   SIGN (fix result signs), STORE (write back). A zero divisor diverts LOAD
//   to ERR, which raises the sticky DivZero flag.
// Ports
//   Clock : rising-edge clock
//   Reset : synchronous, active-high; returns to IDLE with all outputs low
//   bus   : div_sequencer_if.master -- Start/sign/status inputs, Busy/Done/
//           DivZero handshake and all bitslice strobes
module div_sequencer #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic            Clock,
  input  logic            Reset,
  div_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    SIGN,
    STORE,
    ERR
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          dz_q, dz_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic load_q, load_d;
  logic iter_q, iter_d;
  logic inv1_q, inv1_d;
  logic inv2_q, inv2_d;
  logic invres_q, invres_d;
  logic invrem_q, invrem_d;
  logic store_q, store_d;

  // Next state, counter and sign/flag latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          s1_d    = bus.Op1Sign;
          s2_d    = bus.Op2Sign;
          dz_d    = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (bus.Op2Zero) begin
          dz_d    = 1'b1;
          state_d = ERR;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        // counter stops at WIDTH on exit, so it never wraps
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = SIGN;
      end
      SIGN:    state_d = STORE;
      STORE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs are decoded from the next state and registered, so each
  // strobe appears in the same cycle as its state yet leaves a flop.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == STORE) || (state_d == ERR);
    load_d   = (state_d == LOAD);
    iter_d   = (state_d == ITER);
    inv1_d   = (state_d == LOAD) && s1_d;
    inv2_d   = (state_d == LOAD) && s2_d;
    invres_d = (state_d == SIGN) && (s1_d ^ s2_d);
    invrem_d = (state_d == SIGN) && s1_d;
    store_d  = (state_d == STORE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      iter_q   <= 1'b0;
      inv1_q   <= 1'b0;
      inv2_q   <= 1'b0;
      invres_q <= 1'b0;
      invrem_q <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      load_q   <= load_d;
      iter_q   <= iter_d;
      inv1_q   <= inv1_d;
      inv2_q   <= inv2_d;
      invres_q <= invres_d;
      invrem_q <= invrem_d;
      store_q  <= store_d;
    end
  end

  assign bus.Busy           = busy_q;
  assign bus.Done           = done_q;
  assign bus.DivZero        = dz_q;
  assign bus.LOAD_DIVH      = load_q;
  assign bus.LOAD_DIVL      = load_q;
  assign bus.INV_OP1        = inv1_q;
  assign bus.OP1_INV_Cin    = inv1_q;
  assign bus.INV_OP2        = inv2_q;
  assign bus.OP2_INV_Cin    = inv2_q;
  assign bus.DIVH_P         = iter_q;
  assign bus.DIVL_P         = iter_q;
  assign bus.INV_RESULT     = invres_q;
  assign bus.RESULT_INV_Cin = invres_q;
  assign bus.INV_REM        = invrem_q;
  assign bus.STORE_QUOT     = store_q;
  assign bus.STORE_REM      = store_q;

  // Quotient bit and accumulator commit follow the live trial sign.
  assign bus.LOAD_ACC = (state_q == ITER) && !bus.Trial_Neg;
  assign bus.RESULT_P = (state_q == ITER) && !bus.Trial_Neg;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if bus();

  div_sequencer #(.WIDTH(W)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an operation is described only by the edge t0 that
  // accepted it; cycle k = cyc - t0 after that edge selects the phase.
  bit m_on = 1'b0;
  bit m_act = 1'b0;
  bit m_zero = 1'b0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) begin
    int k;
    int last;
    k = cyc - t0;
    if (rst) begin
      m_on  = 1'b1;
      m_act = 1'b0;
    end else if (m_on) begin
      if (m_act && k == 1) m_zero = bus.Op2Zero;
      last = m_zero ? 2 : W + 3;
      if (!m_act || k > last) begin
        if (bus.Start) begin
          m_act  = 1'b1;
          t0     = cyc;
          m_zero = 1'b0;
          m_s1   = bus.Op1Sign;
          m_s2   = bus.Op2Sign;
        end
      end
    end
    cyc++;
  end

  function automatic logic [17:0] dut_vec();
    return {bus.Busy, bus.Done, bus.DivZero, bus.LOAD_DIVH, bus.LOAD_DIVL,
            bus.INV_OP1, bus.OP1_INV_Cin, bus.INV_OP2, bus.OP2_INV_Cin,
            bus.DIVH_P, bus.DIVL_P, bus.LOAD_ACC, bus.RESULT_P,
            bus.INV_RESULT, bus.RESULT_INV_Cin, bus.INV_REM,
            bus.STORE_QUOT, bus.STORE_REM};
  endfunction

  always @(negedge clk) begin
    int k;
    logic ld, it, sg, st, er, bz, dz, acc;
    logic [17:0] exp;
    int groups;
    if (m_on) begin
      k  = cyc - t0;
      ld = m_act && k == 1;
      it = m_act && !m_zero && k >= 2 && k <= W + 1;
      sg = m_act && !m_zero && k == W + 2;
      st = m_act && !m_zero && k == W + 3;
      er = m_act && m_zero && k == 2;
      bz = m_act && k >= 1 && k <= (m_zero ? 2 : W + 3);
      dz = m_act && m_zero && k >= 2;
      acc = it && !bus.Trial_Neg;
      exp = {bz, st || er, dz, ld, ld, ld && m_s1, ld && m_s1, ld && m_s2, ld && m_s2,
             it, it, acc, acc, sg && (m_s1 ^ m_s2), sg && (m_s1 ^ m_s2), sg && m_s1, st, st};
      check("outputs", 32'(dut_vec()), 32'(exp));
      groups = int'(bus.LOAD_DIVH | bus.LOAD_DIVL) + int'(bus.DIVH_P | bus.DIVL_P)
             + int'(bus.STORE_QUOT | bus.STORE_REM);
      check("group_exclusive", 32'(groups <= 1), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int done_at;
    int done_n;
    int busy_n;
    int divh_n;
    int store_n;
    logic [7:0] rp;
    logic [7:0] la;
    logic [3:0] ld_inv;
    logic [2:0] sg_inv;
    logic dz1;
    logic dz2;
  } op_res_t;

  // Start one operation (accepted at edge 0) and observe cycles 1..W+4.
  task automatic run_op(input logic s1, input logic s2, input logic z,
                        input logic [7:0] tn, output op_res_t r);
    r = '{done_at: -1, done_n: 0, busy_n: 0, divh_n: 0, store_n: 0,
          rp: '0, la: '0, ld_inv: '0, sg_inv: '0, dz1: 1'b0, dz2: 1'b0};
    bus.Start   = 1'b1;
    bus.Op1Sign = s1;
    bus.Op2Sign = s2;
    bus.Op2Zero = z;
    tick();
    bus.Start = 1'b0;
    for (int k = 1; k <= int'(W) + 4; k++) begin
      bus.Trial_Neg = (k >= 2 && k <= int'(W) + 1) ? tn[int'(W) + 1 - k] : 1'b0;
      @(negedge clk);
      if (bus.Busy) r.busy_n++;
      if (bus.DIVH_P) r.divh_n++;
      if (bus.STORE_QUOT || bus.STORE_REM) r.store_n++;
      if (bus.Done) begin
        r.done_n++;
        if (r.done_at < 0) r.done_at = k;
      end
      if (k >= 2 && k <= int'(W) + 1) begin
        r.rp = {r.rp[6:0], bus.RESULT_P};
        r.la = {r.la[6:0], bus.LOAD_ACC};
      end
      if (k == 1) begin
        r.ld_inv = {bus.INV_OP1, bus.OP1_INV_Cin, bus.INV_OP2, bus.OP2_INV_Cin};
        r.dz1 = bus.DivZero;
      end
      if (k == 2) r.dz2 = bus.DivZero;
      if (k == int'(W) + 2) r.sg_inv = {bus.INV_RESULT, bus.RESULT_INV_Cin, bus.INV_REM};
      tick();
    end
    bus.Op2Zero = 1'b0;
  endtask

  initial begin
    op_res_t r;
    int d1, d2, dn;
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Op1Sign = 1'b0;
    bus.Op2Sign = 1'b0;
    bus.Op2Zero = 1'b0;
    bus.Trial_Neg = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset_vec", 32'(dut_vec()), 32'd0);
    rst = 1'b0;
    tick();

    // plain positive division with a fixed trial-sign pattern
    run_op(1'b0, 1'b0, 1'b0, 8'b1111_0110, r);
    check("t1_done_at", r.done_at, 11);
    check("t1_done_n", r.done_n, 1);
    check("t1_busy_n", r.busy_n, 11);
    check("t1_divh_n", r.divh_n, 8);
    check("t1_store_n", r.store_n, 1);
    check("t2_result_p", 32'(r.rp), 32'h09);
    check("t2_load_acc", 32'(r.la), 32'h09);

    // sign handling
    run_op(1'b1, 1'b0, 1'b0, 8'($urandom), r);
    check("t3a_load_inv", 32'(r.ld_inv), 32'hC);
    check("t3a_sign_inv", 32'(r.sg_inv), 32'h7);
    run_op(1'b1, 1'b1, 1'b0, 8'($urandom), r);
    check("t3b_load_inv", 32'(r.ld_inv), 32'hF);
    check("t3b_sign_inv", 32'(r.sg_inv), 32'h1);

    // divide by zero, then the next Start clears DivZero
    run_op(1'b0, 1'b0, 1'b1, 8'($urandom), r);
    check("t4_done_at", r.done_at, 2);
    check("t4_busy_n", r.busy_n, 2);
    check("t4_divh_n", r.divh_n, 0);
    check("t4_store_n", r.store_n, 0);
    check("t4_divzero", 32'(r.dz2), 32'd1);
    @(negedge clk);
    check("t4_divzero_held", 32'(bus.DivZero), 32'd1);
    run_op(1'b0, 1'b1, 1'b0, 8'($urandom), r);
    check("t4_divzero_cleared", 32'(r.dz1), 32'd0);
    check("t4_next_done_at", r.done_at, 11);
    check("t4_next_sign_inv", 32'(r.sg_inv), 32'h6);

    // reset during ITER cycle 4
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.Trial_Neg = 1'($urandom);
      if (k == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    bus.Trial_Neg = 1'b0;
    @(negedge clk);
    check("t5_after_reset", 32'(dut_vec()), 32'd0);
    run_op(1'b0, 1'b0, 1'b0, 8'($urandom), r);
    check("t5_fresh_done_at", r.done_at, 11);

    // Start while busy is ignored; Start in IDLE after Done is accepted
    bus.Start = 1'b1;
    tick();
    d1 = -1;
    d2 = -1;
    dn = 0;
    for (int k = 1; k <= 25; k++) begin
      bus.Start = (k == 3 || k == 11 || k == 12);
      bus.Trial_Neg = 1'($urandom);
      @(negedge clk);
      if (bus.Done) begin
        dn++;
        if (d1 < 0) d1 = k;
        else d2 = k;
      end
      tick();
    end
    bus.Start = 1'b0;
    check("t6_done_n", dn, 2);
    check("t6_first_done", d1, 11);
    check("t6_second_done", d2, 23);

    // randomized traffic checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 149) == 0);
      bus.Start     = ($urandom_range(0, 3) == 0);
      bus.Op1Sign   = 1'($urandom);
      bus.Op2Sign   = 1'($urandom);
      bus.Op2Zero   = ($urandom_range(0, 7) == 0);
      bus.Trial_Neg = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    bus.Start = 1'b0;
    tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
